lmfe_pixel_src: RTL and testbench

LMFE_PIXEL_SRC -- requirements
Module: lmfe_pixel_src

---
 rtl/lmfe_pkg.sv | 17 +
 rtl/lmfe_skid_fifo.sv | 56 +++++
 rtl/lmfe_pixel_src.sv | 154 +++++++++++++++
 tb/tb_lmfe_pixel_src.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lmfe_pkg.sv
// Shared constants and types for the LMFE pixel source.
// Holds pixel width, default geometry and the source FSM state enum.
package lmfe_pkg;

    localparam int PIX_W      = 8;
    localparam int IMG_W_DEF  = 128;
    localparam int IMG_H_DEF  = 128;
    localparam int ADDR_W_DEF = 14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } src_state_t;

endpackage

// File: rtl/lmfe_skid_fifo.sv
// Two-entry FIFO between ROM read data and the filter input.
// Push and pop in the same cycle are allowed, including when full.
module lmfe_skid_fifo
    import lmfe_pkg::*;
#(
    parameter int W = PIX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         wr_en;
    logic         rd_en;

    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    // Storage, pointers and occupancy; a write into a full FIFO
    // reuses the slot being popped in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lmfe_pixel_src.sv
// Streams one frame from ROM in raster order into the median filter.
// Optional macro LMFE_SRC_STALL_CNT_EN adds a 16-bit stall_cnt output.
module lmfe_pixel_src
    import lmfe_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [PIX_W-1:0]  Din,
    output logic              in_en,
    input  logic              busy,
    output logic              active,
    output logic              done
`ifdef LMFE_SRC_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int N = IMG_W * IMG_H;
    localparam logic [ADDR_W:0] CNT_N    = (ADDR_W + 1)'(N);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(N - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    src_state_t state;
    src_state_t state_nx;

    logic [ADDR_W:0] issue_cnt;
    logic [ADDR_W:0] acc_cnt;
    logic            rd_q;
    logic            run_entry;
    logic [2:0]      slots_used;

    logic             fifo_empty;
    logic             fifo_full;
    logic [1:0]       fifo_cnt;
    logic [PIX_W-1:0] fifo_head;

    lmfe_skid_fifo #(
        .W (PIX_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (rd_q),
        .pop   (in_en),
        .din   (rom_data),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_cnt)
    );

    assign in_en    = !fifo_empty && !busy;
    assign Din      = in_en ? fifo_head : '0;
    assign rom_addr = issue_cnt[ADDR_W-1:0];

    // Slots committed after this edge: stored, in flight, minus the pop.
    assign slots_used = {1'b0, fifo_cnt}
                      + {2'b00, rd_q}
                      - {2'b00, in_en};

    assign rom_rd = (state == S_RUN)
                 && (issue_cnt < CNT_N)
                 && (slots_used < 3'd2)
                 && !(fifo_full && !in_en);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx  = state;
        run_entry = 1'b0;
        active    = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx  = S_RUN;
                    run_entry = 1'b1;
                end
            end
            S_RUN: begin
                active = 1'b1;
                if (rom_rd && issue_cnt == CNT_LAST) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                active = 1'b1;
                if (in_en && acc_cnt == CNT_LAST) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                active   = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Issue/accept counters and the one-cycle ROM latency tracker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_cnt <= '0;
            acc_cnt   <= '0;
            rd_q      <= 1'b0;
        end else begin
            rd_q <= rom_rd;
            if (run_entry) begin
                issue_cnt <= '0;
                acc_cnt   <= '0;
            end else begin
                if (rom_rd) begin
                    issue_cnt <= issue_cnt + CNT_ONE;
                end
                if (in_en) begin
                    acc_cnt <= acc_cnt + CNT_ONE;
                end
            end
        end
    end

`ifdef LMFE_SRC_STALL_CNT_EN
    // Saturating count of cycles where a ready pixel is held off by busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (run_entry) begin
            stall_cnt <= '0;
        end else if ((state == S_RUN || state == S_DRAIN)
                  && !fifo_empty && busy
                  && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lmfe_pixel_src.sv
// Directed bench for lmfe_pixel_src (16x32 frame and a 4x2 frame).
// Define LMFE_SRC_STALL_CNT_EN to also check stall_cnt.
`timescale 1ns/1ps
module tb_lmfe_pixel_src;

    localparam int W  = 16;
    localparam int H  = 32;
    localparam int AW = 9;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy = 1'b1;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = 8'h00;
    logic [7:0]    din;
    logic          in_en;
    logic          active;
    logic          done;
`ifdef LMFE_SRC_STALL_CNT_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   s_stall_cnt;
`endif

    logic          s_start = 1'b0;
    logic          s_busy = 1'b0;
    logic          s_rom_rd;
    logic [2:0]    s_rom_addr;
    logic [7:0]    s_rom_data = 8'h00;
    logic [7:0]    s_din;
    logic          s_in_en;
    logic          s_active;
    logic          s_done;

    int checks = 0;
    int errors = 0;

    lmfe_pixel_src #(
        .IMG_W (W), .IMG_H (H), .ADDR_W (AW)
    ) dut (
        .clk (clk), .reset (reset), .start (start),
        .rom_rd (rom_rd), .rom_addr (rom_addr),
        .rom_data (rom_data), .Din (din), .in_en (in_en),
        .busy (busy), .active (active), .done (done)
`ifdef LMFE_SRC_STALL_CNT_EN
        , .stall_cnt (stall_cnt)
`endif
    );

    lmfe_pixel_src #(
        .IMG_W (4), .IMG_H (2), .ADDR_W (3)
    ) dut_s (
        .clk (clk), .reset (reset), .start (s_start),
        .rom_rd (s_rom_rd), .rom_addr (s_rom_addr),
        .rom_data (s_rom_data), .Din (s_din),
        .in_en (s_in_en), .busy (s_busy),
        .active (s_active), .done (s_done)
`ifdef LMFE_SRC_STALL_CNT_EN
        , .stall_cnt (s_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ROM models: data is the low address byte, one cycle after rd.
    always @(posedge clk) begin
        rom_data   <= rom_rd ? rom_addr[7:0] : 8'h00;
        s_rom_data <= s_rom_rd ? {5'b0, s_rom_addr} : 8'h00;
    end

    int xfer_tot  = 0;
    int order_err = 0;
    int busy_viol = 0;
    int done_tot  = 0;
    int base      = 0;

    // Transfer monitor: pixel k of the frame must carry k[7:0].
    always @(negedge clk) begin
        if (in_en) begin
            if (din !== 8'(xfer_tot - base)) order_err++;
            xfer_tot++;
        end
        if (in_en && busy) busy_viol++;
        if (done) done_tot++;
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    // Runs one frame on the large DUT with a busy pattern:
    // 0 idle, 1 one-of-three busy, 2 fifty-cycle stall after
    // pixel 10, 3 extra start at cycle 100, 4 stop at pixel 300.
    task automatic run_frame(input  int mode,
                             output int cyc_done,
                             output int first_rd,
                             output int first_en,
                             output logic [7:0] first_din,
                             output int rd_busy,
                             output int inactive);
        int stall_left;
        stall_left = 50;
        cyc_done  = -1;
        first_rd  = -1;
        first_en  = -1;
        first_din = 8'hEE;
        rd_busy   = 0;
        inactive  = 0;
        base      = xfer_tot;
        @(posedge clk); #1 start = 1'b1;
        for (int c = 1; c <= 3 * N + 100; c++) begin
            @(posedge clk); #1;
            start = (mode == 3 && c == 100);
            if (mode == 1) begin
                busy = (c % 3 == 0);
            end else if (mode == 2 && (xfer_tot - base) == 11
                         && stall_left > 0) begin
                busy = 1'b1;
                stall_left--;
            end else begin
                busy = 1'b0;
            end
            if (mode == 4 && (xfer_tot - base) >= 300) return;
            @(negedge clk);
            if (rom_rd && first_rd < 0) first_rd = c;
            if (in_en && first_en < 0) begin
                first_en  = c;
                first_din = din;
            end
            if (rom_rd && busy) rd_busy++;
            if (!active) inactive++;
            if (done) begin
                cyc_done = c;
                break;
            end
        end
    endtask

    int cd, frd, fen, rdb, inact, d0, x0, bv0;
    int s_x, s_oe, s_cd, s_idle;
    logic [7:0] fdin;

    initial begin
        // Reset state, with busy high and start low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_rd", rom_rd, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_in_en", in_en, 0);
        chk("rst_din", din, 0);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
`ifdef LMFE_SRC_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Free-running frame.
        d0 = done_tot;
        run_frame(0, cd, frd, fen, fdin, rdb, inact);
        chk("a_done_cycle", cd, N + 3);
        chk("a_first_rd", frd, 1);
        chk("a_first_en", fen, 3);
        chk("a_first_din", fdin, 0);
        chk("a_active_gap", inact, 0);
        repeat (2) @(negedge clk);
        chk("a_xfers", xfer_tot - base, N);
        chk("a_order", order_err, 0);
        chk("a_idle", active, 0);
        chk("a_done_cnt", done_tot - d0, 1);

        // One-of-three busy.
        bv0 = busy_viol;
        run_frame(1, cd, frd, fen, fdin, rdb, inact);
        repeat (2) @(negedge clk);
        chk("b_finished", cd > 0, 1);
        chk("b_xfers", xfer_tot - base, N);
        chk("b_order", order_err, 0);
        chk("b_en_busy", busy_viol - bv0, 0);

        // Fifty-cycle stall after pixel 10.
        run_frame(2, cd, frd, fen, fdin, rdb, inact);
        chk("c_done_cycle", cd, N + 53);
        chk("c_rd_in_stall", rdb, 0);
`ifdef LMFE_SRC_STALL_CNT_EN
        chk("c_stall_cnt", stall_cnt, 50);
`endif
        repeat (2) @(negedge clk);
        chk("c_xfers", xfer_tot - base, N);
        chk("c_order", order_err, 0);

        // Reset in the middle of a frame, then restart.
        run_frame(4, cd, frd, fen, fdin, rdb, inact);
        reset = 1'b0;
        #1;
        chk("d_rom_rd", rom_rd, 0);
        chk("d_rom_addr", rom_addr, 0);
        chk("d_in_en", in_en, 0);
        chk("d_din", din, 0);
        chk("d_active", active, 0);
        chk("d_done", done, 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        run_frame(0, cd, frd, fen, fdin, rdb, inact);
        chk("d_first_din", fdin, 0);
        chk("d_done_cycle", cd, N + 3);
        repeat (2) @(negedge clk);
        chk("d_xfers", xfer_tot - base, N);
        chk("d_order", order_err, 0);

        // Second start while running is ignored.
        d0 = done_tot;
        run_frame(3, cd, frd, fen, fdin, rdb, inact);
        chk("e_done_cycle", cd, N + 3);
        repeat (20) @(negedge clk);
        chk("e_done_cnt", done_tot - d0, 1);
        chk("e_xfers", xfer_tot - base, N);
        chk("e_idle", active, 0);
        chk("e_order", order_err, 0);

        // Tiny 4x2 frame on the second instance.
        s_x = 0; s_oe = 0; s_cd = -1; s_idle = -1;
        @(posedge clk); #1 s_start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1 s_start = 1'b0;
            @(negedge clk);
            if (s_in_en) begin
                if (s_din !== 8'(s_x)) s_oe++;
                s_x++;
            end
            if (s_done && s_cd < 0) s_cd = c;
            if (c == 12) s_idle = s_active ? 0 : 1;
        end
        chk("f_xfers", s_x, 8);
        chk("f_order", s_oe, 0);
        chk("f_done_cycle", s_cd, 11);
        chk("f_idle_after", s_idle, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
